// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF controller: FSM states,
// challenge LFSR constants and the LFSR step function.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      COUNT   = 3'd2,
      COMPARE = 3'd3,
      DONE    = 3'd4
   } puf_state_e;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam int          SETTLE_LEN   = 4;

   // Galois form, x^16+x^14+x^13+x^11+1, shifting towards the LSB
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] nxt;
      if (cur[0]) begin
         nxt = (cur >> 1'b1) ^ LFSR_TAPS;
      end else begin
         nxt = cur >> 1'b1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of one asynchronous oscillator: 2-flop synchroniser,
// edge detector and a saturating counter with synchronous clear/enable.
module ro_edge_counter
   import ro_puf_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ro_in,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q, prev_d;
   logic [CNT_W-1:0] count_q, count_d;

   // synchroniser pipeline and saturating edge count
   always_comb begin
      sync1_d = ro_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      count_d = count_q;
      if (clear) begin
         count_d = {CNT_W{1'b0}};
      end else if (enable && sync2_q && !prev_q && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         count_q <= {CNT_W{1'b0}};
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ro_puf_array_ctrl.sv
// Ring-oscillator PUF controller: walks an LFSR-chosen sequence of oscillator
// pairs, races each pair over a fixed window and packs the winners into resp.
module ro_puf_array_ctrl
   import ro_puf_pkg::*;
#(
   parameter int NUM_RO    = 16,
   parameter int CNT_W     = 16,
   parameter int WINDOW    = 1024,
   parameter int RESP_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [15:0]          challenge,
   input  logic [NUM_RO-1:0]    ro_out,
   output logic [NUM_RO-1:0]    ro_enable,
   output logic [RESP_BITS-1:0] resp,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 busy,
   output logic                 tie_flag
);

   localparam int SEL_W = $clog2(NUM_RO);
   localparam int TMR_W = 21;
   localparam int IDX_W = 6;

   puf_state_e           state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [RESP_BITS-1:0] resp_q, resp_d;
   logic                 tie_q, tie_d;
   logic                 resp_valid_q, resp_valid_d;
   logic                 busy_q, busy_d;
   logic [NUM_RO-1:0]    ro_en_q, ro_en_d;

   logic [SEL_W-1:0]     sel_a_s, sel_b_s, sel_a_n, sel_b_n;
   logic                 ro_a_s, ro_b_s;
   logic                 cnt_clear_s, cnt_enable_s, bit_s;
   logic [CNT_W-1:0]     count_a_s, count_b_s;

   // a colliding pair is broken by taking the next oscillator, wrapping round
   function automatic logic [2*SEL_W-1:0] pair_sel(input logic [15:0] lfsr);
      logic [SEL_W-1:0] a;
      logic [SEL_W-1:0] b;
      a = lfsr[SEL_W-1:0];
      b = lfsr[2*SEL_W-1:SEL_W];
      if (a == b) begin
         b = a + {{(SEL_W-1){1'b0}}, 1'b1};
      end else begin
         b = lfsr[2*SEL_W-1:SEL_W];
      end
      return {b, a};
   endfunction

   // pair selection for the current and the upcoming LFSR value
   always_comb begin
      {sel_b_s, sel_a_s} = pair_sel(lfsr_q);
      {sel_b_n, sel_a_n} = pair_sel(lfsr_d);
   end

   assign ro_a_s       = ro_out[sel_a_s];
   assign ro_b_s       = ro_out[sel_b_s];
   assign cnt_clear_s  = (state_q == SETTLE);
   assign cnt_enable_s = (state_q == COUNT);
   assign bit_s        = (count_a_s > count_b_s);

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk    (clk),
      .reset  (reset),
      .ro_in  (ro_a_s),
      .clear  (cnt_clear_s),
      .enable (cnt_enable_s),
      .count  (count_a_s)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk    (clk),
      .reset  (reset),
      .ro_in  (ro_b_s),
      .clear  (cnt_clear_s),
      .enable (cnt_enable_s),
      .count  (count_b_s)
   );

   // next-state and datapath updates of the evaluation sequence
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      tmr_d   = tmr_q;
      idx_d   = idx_q;
      resp_d  = resp_q;
      tie_d   = tie_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               lfsr_d  = (challenge == 16'h0000) ? DEFAULT_SEED : challenge;
               resp_d  = {RESP_BITS{1'b0}};
               tie_d   = 1'b0;
               idx_d   = {IDX_W{1'b0}};
               tmr_d   = {TMR_W{1'b0}};
               state_d = SETTLE;
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            if (tmr_q == TMR_W'(SETTLE_LEN - 1)) begin
               tmr_d   = {TMR_W{1'b0}};
               state_d = COUNT;
            end else begin
               tmr_d   = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
            end
         end
         COUNT: begin
            if (tmr_q == TMR_W'(WINDOW - 1)) begin
               tmr_d   = {TMR_W{1'b0}};
               state_d = COMPARE;
            end else begin
               tmr_d   = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
            end
         end
         COMPARE: begin
            resp_d = resp_q | ({{(RESP_BITS-1){1'b0}}, bit_s} << idx_q);
            tie_d  = tie_q | (count_a_s == count_b_s);
            lfsr_d = lfsr_next(lfsr_q);
            idx_d  = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            if ((idx_q + {{(IDX_W-1){1'b0}}, 1'b1}) < IDX_W'(RESP_BITS)) begin
               state_d = SETTLE;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // registered outputs are derived from the next state so they line up with it
   always_comb begin
      busy_d       = (state_d != IDLE);
      resp_valid_d = (state_d == DONE);
      if ((state_d == SETTLE) || (state_d == COUNT)) begin
         ro_en_d = ({{(NUM_RO-1){1'b0}}, 1'b1} << sel_a_n)
                 | ({{(NUM_RO-1){1'b0}}, 1'b1} << sel_b_n);
      end else begin
         ro_en_d = {NUM_RO{1'b0}};
      end
   end

   // state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         lfsr_q       <= 16'h0000;
         tmr_q        <= {TMR_W{1'b0}};
         idx_q        <= {IDX_W{1'b0}};
         resp_q       <= {RESP_BITS{1'b0}};
         tie_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         ro_en_q      <= {NUM_RO{1'b0}};
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         tmr_q        <= tmr_d;
         idx_q        <= idx_d;
         resp_q       <= resp_d;
         tie_q        <= tie_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         ro_en_q      <= ro_en_d;
      end
   end

   assign ro_enable  = ro_en_q;
   assign resp       = resp_q;
   assign resp_valid = resp_valid_q;
   assign busy       = busy_q;
   assign tie_flag   = tie_q;

endmodule

// File: doc/ro_puf_array_ctrl.md
RO_PUF_ARRAY_CTRL -- requirements
Module: ro_puf_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_RO, default 16: ring oscillators in the bank; power of 2, 4..256.
REQ-002 SHALL have parameter CNT_W, default 16: edge-counter width.
REQ-003 SHALL have parameter WINDOW, default 1024: measurement window in clk cycles; 1..2^20.
REQ-004 SHALL have parameter RESP_BITS, default 8: response bits per challenge; 1..32.
REQ-005 SHALL have ports clk  in  1  system clock; reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports start  in  1  begin evaluation pulse; challenge  in  16  LFSR seed, sampled on accepted start.
REQ-007 SHALL have ports ro_out  in  NUM_RO  raw oscillator outputs, asynchronous to clk; ro_enable  out  NUM_RO  one-hot-pair oscillator enables.
REQ-008 SHALL have ports resp  out  RESP_BITS  PUF response; resp_valid  out  1; resp_ready  in  1; busy  out  1; tie_flag  out  1  any bit decided by equal counts.

Function
REQ-009 SHALL implement FSM states IDLE, SETTLE, COUNT, COMPARE, DONE.
REQ-010 SHALL accept start only in IDLE, load LFSR with challenge (16'hACE1 if challenge==0), clear resp, tie_flag and bit index, then enter SETTLE; start in any other state is ignored.
REQ-011 SHALL use a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (taps 16'hB400), advanced exactly once per COMPARE.
REQ-012 SHALL derive SEL_W=clog2(NUM_RO), sel_a=lfsr[SEL_W-1:0], sel_b=lfsr[2*SEL_W-1:SEL_W]; if sel_a==sel_b then sel_b=(sel_a+1) mod NUM_RO; for NUM_RO=256, sel_b uses lfsr[15:8].
REQ-013 SHALL assert ro_enable only for bits sel_a and sel_b in SETTLE and COUNT; all zero otherwise.
REQ-014 SHALL hold SETTLE exactly 4 cycles, clearing both counters, then enter COUNT.
REQ-015 SHALL pass each selected ro_out through a 2-flop synchroniser and count rising edges of the synchronised signal only during COUNT, which lasts exactly WINDOW cycles.
REQ-016 SHALL saturate counters at 2^CNT_W-1, never wrapping.
REQ-017 SHALL in COMPARE (1 cycle) compute bit = (count_a > count_b), shift it into resp LSB-first at bit index, set tie_flag if counts equal (bit=0), advance LFSR and bit index.
REQ-018 SHALL return from COMPARE to SETTLE if bit index < RESP_BITS, else enter DONE.
REQ-019 SHALL in DONE hold resp_valid=1 and resp stable until a cycle with resp_ready=1, then enter IDLE with resp_valid=0 next cycle; resp retains its value until next accepted start.
REQ-020 SHALL drive busy=1 in every state except IDLE.
REQ-021 SHALL produce total latency start->resp_valid = RESP_BITS*(4+WINDOW+1)+1 cycles.

Reset
REQ-022 SHALL on reset assertion immediately force IDLE, resp=0, resp_valid=0, busy=0, tie_flag=0, ro_enable=0, counters, synchronisers and LFSR to 0.
REQ-023 SHALL treat reset mid-evaluation as abort: no partial response is presented; the next start begins a fresh evaluation.

Structure
REQ-024 SHALL place FSM state enum, LFSR taps constant, default seed 16'hACE1 and SETTLE length 4 in shared package ro_puf_pkg.
REQ-025 SHALL use one sub-module ro_edge_counter (synchroniser, edge detect, saturating counter, clear/enable), instantiated twice.
REQ-026 SHALL use no combinational loops; oscillators remain outside this block.

Verification
REQ-027 SHALL verify with NUM_RO=8, WINDOW=64, RESP_BITS=8: ro_out[k] toggling every (k+2) clk cycles -> counts per window differ deterministically; resp matches a reference model of REQ-011/012/017 bit-exact.
REQ-028 SHALL verify challenge=0 -> LFSR seeded 16'hACE1; challenge=16'h0001 -> first pair sel_a=1, sel_b=0 (0 collides? no: sel_b=lfsr[5:3]=0), bit0=1 when ro1 faster.
REQ-029 SHALL verify all ro_out static -> both counts 0, resp=8'h00, tie_flag=1, resp_valid after exactly 8*69+1=553 cycles.
REQ-030 SHALL verify resp_ready held low 20 cycles in DONE -> resp_valid and resp stable; second start during busy ignored.
REQ-031 SHALL verify CNT_W=4 with fast ro_out -> counts saturate at 15, tie_flag=1.
REQ-032 SHALL verify reset asserted mid-COUNT -> all outputs zero same cycle, IDLE, ro_enable=0.
